// File: rtl/if_fetch_unit.sv
// Instruction fetch stage feeding the IF/ID register.
// Keeps an 8-bit word-addressed PC, issues one outstanding request at a time
// to instruction memory, and buffers returned words with their fetch address
// in a small FIFO that decode drains under a valid/stall handshake.
// A redirect empties the buffer and marks any in-flight response for discard.
module if_fetch_unit #(
    parameter int         DEPTH    = 2,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        pc_src,
    input  logic [7:0]  branch_addr,
    input  logic        id_stall,
    output logic        if_valid,
    output logic [15:0] instruc_out,
    output logic [7:0]  addr_out
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [7:0]    pc;
    logic [7:0]    req_addr;
    logic          outstanding;
    logic          drop;
    logic [7:0]    fifo_addr  [DEPTH];
    logic [15:0]   fifo_instr [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic grant;
    logic resp;
    logic push;
    logic pop;

    // Request and handshake qualifiers; a redirect or reset suppresses the request outright.
    always_comb begin
        imem_req  = !outstanding && (count < FULL) && !pc_src && !rst;
        imem_addr = rst ? 8'h00 : pc;
        grant     = imem_req && imem_gnt;
        resp      = imem_rvalid && outstanding;
        push      = resp && !drop && !pc_src;
        if_valid  = !rst && (count != '0);
        pop       = if_valid && !id_stall;
    end

    // Head-of-buffer presentation, forced to zero whenever nothing valid is held.
    always_comb begin
        instruc_out = 16'h0000;
        addr_out    = 8'h00;
        if (if_valid) begin
            instruc_out = fifo_instr[head];
            addr_out    = fifo_addr[head];
        end
    end

    // PC, request tracking and buffer occupancy; redirect overrides everything but reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            req_addr    <= 8'h00;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else if (pc_src) begin
            pc    <= branch_addr;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // A response landing in the redirect cycle is simply discarded;
            // otherwise the one still in flight must be dropped on arrival.
            if (outstanding) begin
                if (imem_rvalid) begin
                    outstanding <= 1'b0;
                    drop        <= 1'b0;
                end else begin
                    drop <= 1'b1;
                end
            end
        end else begin
            if (grant) begin
                outstanding <= 1'b1;
                req_addr    <= pc;
                pc          <= pc + 8'd1;
            end
            if (resp) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer storage; written only by an accepted response, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_addr[tail]  <= req_addr;
            fifo_instr[tail] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic [7:0] RPC = 8'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        pc_src;
    logic [7:0]  branch_addr;
    logic        id_stall;
    logic        if_valid;
    logic [15:0] instruc_out;
    logic [7:0]  addr_out;

    always #5 clk = ~clk;

    if_fetch_unit #(.DEPTH(2), .RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_src      (pc_src),
        .branch_addr (branch_addr),
        .id_stall    (id_stall),
        .if_valid    (if_valid),
        .instruc_out (instruc_out),
        .addr_out    (addr_out)
    );

    int vectors = 0;
    int miscompares = 0;

    // memory model
    logic [15:0] mem [256];
    bit          mem_busy = 0;
    logic [7:0]  mem_a;
    int          mem_lat;
    int          gnt_prob = 100;
    int          lat_min = 1;
    int          lat_max = 1;

    // reference: next address to fetch and next address decode should see
    logic [7:0]  exp_fetch = RPC;
    logic [7:0]  exp_out = RPC;

    // values sampled in the most recent cycle
    logic        s_req, s_valid, s_gnt;
    logic [7:0]  s_addr, s_aout;
    logic [15:0] s_instr;
    logic [7:0]  pop_log[$];
    int          n_pops = 0;

    // one clock cycle: called at negedge with scenario inputs already driven
    task automatic tick();
        imem_rvalid = mem_busy && (mem_lat == 0);
        imem_rdata  = imem_rvalid ? mem[mem_a] : 16'($urandom);
        imem_gnt    = !mem_busy && ($urandom_range(99) < gnt_prob);
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = if_valid;
        s_instr = instruc_out;
        s_aout  = addr_out;
        s_gnt   = imem_gnt;
        if (rst) begin
            vectors++;
            if ({s_req, s_addr, s_valid, s_instr, s_aout} !== '0) begin
                miscompares++;
                $display("FAIL rst_outputs: got req=%b addr=%h valid=%b instr=%h aout=%h want all 0",
                         s_req, s_addr, s_valid, s_instr, s_aout);
            end
        end else begin
            if (pc_src) begin
                vectors++;
                if (s_req !== 1'b0) begin
                    miscompares++;
                    $display("FAIL req_in_redirect: got req=%b want 0", s_req);
                end
            end
            if (s_req) begin
                vectors++;
                if (s_addr !== exp_fetch) begin
                    miscompares++;
                    $display("FAIL fetch_addr: got %h want %h", s_addr, exp_fetch);
                end
            end
            if (!s_valid) begin
                vectors++;
                if (s_aout !== 8'h00 || s_instr !== 16'h0000) begin
                    miscompares++;
                    $display("FAIL empty_outputs: got aout=%h instr=%h want 00/0000", s_aout, s_instr);
                end
            end else if (!id_stall) begin
                vectors++;
                if (s_aout !== exp_out || s_instr !== mem[exp_out]) begin
                    miscompares++;
                    $display("FAIL pop_stream: got (%h,%h) want (%h,%h)",
                             s_aout, s_instr, exp_out, mem[exp_out]);
                end
                pop_log.push_back(s_aout);
                n_pops++;
                exp_out = exp_out + 8'd1;
            end
        end
        @(posedge clk);
        if (rst) begin
            exp_fetch = RPC;
            exp_out   = RPC;
        end else if (pc_src) begin
            exp_fetch = branch_addr;
            exp_out   = branch_addr;
        end else if (s_req && s_gnt) begin
            exp_fetch = exp_fetch + 8'd1;
        end
        if (mem_busy) begin
            if (mem_lat == 0) mem_busy = 0;
            else mem_lat--;
        end else if (s_req && s_gnt) begin
            mem_busy = 1;
            mem_a    = s_addr;
            mem_lat  = $urandom_range(lat_max - 1, lat_min - 1);
        end
        @(negedge clk);
    endtask

    task automatic redirect(input logic [7:0] target);
        pc_src = 1'b1;
        branch_addr = target;
        tick();
        pc_src = 1'b0;
    endtask

    task automatic test_reset();
        int n0;
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if (s_req !== 1'b0 || s_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got req=%b valid=%b want 0/0", s_req, s_valid);
        end
        rst = 1'b0; id_stall = 1'b0; gnt_prob = 100; lat_min = 1; lat_max = 1;
        tick();
        vectors++;
        if (s_req !== 1'b1 || s_addr !== RPC) begin
            miscompares++;
            $display("FAIL first_req: got req=%b addr=%h want 1/%h", s_req, s_addr, RPC);
        end
        tick();
        vectors++;
        if (s_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: got valid=%b want 0", s_valid);
        end
        tick();
        vectors++;
        if (s_valid !== 1'b1 || s_aout !== RPC || s_instr !== mem[RPC]) begin
            miscompares++;
            $display("FAIL first_out: got valid=%b (%h,%h) want 1 (%h,%h)",
                     s_valid, s_aout, s_instr, RPC, mem[RPC]);
        end
        n0 = n_pops;
        repeat (10) tick();
        vectors++;
        if (n_pops - n0 !== 5) begin
            miscompares++;
            $display("FAIL startup_rate: got %0d pops want 5", n_pops - n0);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        int n0;
        bit done;
        id_stall = 1'b1;
        held = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 5) held = s_instr;
        end
        vectors++;
        if (s_req !== 1'b0 || s_valid !== 1'b1 || s_instr !== held) begin
            miscompares++;
            $display("FAIL backpressure: got req=%b valid=%b instr=%h want 0/1/%h",
                     s_req, s_valid, s_instr, held);
        end
        id_stall = 1'b0;
        n0 = n_pops;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (n_pops >= n0 + 4) done = 1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL resume_timeout: got %0d pops want 4", n_pops - n0);
        end
    endtask

    task automatic test_redirect_inflight();
        bit found;
        lat_min = 3; lat_max = 3; id_stall = 1'b0;
        redirect(8'h05);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (s_req && s_gnt && s_addr == 8'h05) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL grant05_timeout: got no grant want grant at 05");
        end
        redirect(8'h40);
        tick();
        vectors++;
        if (s_valid !== 1'b0 || s_req !== 1'b0) begin
            miscompares++;
            $display("FAIL after_redirect: got valid=%b req=%b want 0/0", s_valid, s_req);
        end
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (s_valid) found = 1;
        end
        vectors++;
        if (!found || s_aout !== 8'h40) begin
            miscompares++;
            $display("FAIL first_after_redirect: got found=%b aout=%h want 1/40", found, s_aout);
        end
    endtask

    task automatic test_redirect_rvalid_pop();
        bit found;
        lat_min = 1; lat_max = 1; gnt_prob = 100; id_stall = 1'b1;
        redirect(8'h20);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (s_req && s_gnt && s_addr == 8'h21) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL grant21_timeout: got no grant want grant at 21");
        end
        id_stall = 1'b0;
        redirect(8'h40);
        vectors++;
        if (s_valid !== 1'b1 || s_aout !== 8'h20) begin
            miscompares++;
            $display("FAIL pop_at_redirect: got valid=%b aout=%h want 1/20", s_valid, s_aout);
        end
        tick();
        vectors++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 8'h40) begin
            miscompares++;
            $display("FAIL refetch_40: got valid=%b req=%b addr=%h want 0/1/40", s_valid, s_req, s_addr);
        end
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (s_valid) found = 1;
        end
        vectors++;
        if (!found || s_aout !== 8'h40) begin
            miscompares++;
            $display("FAIL out_40: got found=%b aout=%h want 1/40", found, s_aout);
        end
    endtask

    task automatic test_wraparound();
        logic [7:0] want [4];
        want = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        gnt_prob = 60; lat_min = 1; lat_max = 3; id_stall = 1'b0;
        redirect(8'hFE);
        pop_log.delete();
        for (int i = 0; i < 200 && pop_log.size() < 4; i++) begin
            id_stall = ($urandom_range(2) == 0);
            tick();
        end
        id_stall = 1'b0;
        vectors++;
        if (pop_log.size() < 4) begin
            miscompares++;
            $display("FAIL wrap_timeout: got %0d pops want 4", pop_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (pop_log[i] !== want[i]) begin
                    miscompares++;
                    $display("FAIL wrap_seq[%0d]: got %h want %h", i, pop_log[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        gnt_prob = 100; lat_min = 5; lat_max = 5; id_stall = 1'b1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (s_valid && mem_busy) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL busy_timeout: got no entry+outstanding want both");
        end
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0; id_stall = 1'b0;
        tick();
        vectors++;
        if (s_req !== 1'b1 || s_addr !== RPC) begin
            miscompares++;
            $display("FAIL req_after_rst: got req=%b addr=%h want 1/%h", s_req, s_addr, RPC);
        end
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (s_valid) found = 1;
        end
        vectors++;
        if (!found || s_aout !== RPC || s_instr !== mem[RPC]) begin
            miscompares++;
            $display("FAIL out_after_rst: got found=%b (%h,%h) want (%h,%h)",
                     found, s_aout, s_instr, RPC, mem[RPC]);
        end
    endtask

    task automatic test_random();
        int n0;
        gnt_prob = 70; lat_min = 1; lat_max = 4;
        n0 = n_pops;
        for (int i = 0; i < 400; i++) begin
            id_stall    = ($urandom_range(3) == 0);
            pc_src      = ($urandom_range(19) == 0);
            branch_addr = 8'($urandom);
            tick();
        end
        pc_src = 1'b0;
        vectors++;
        if (n_pops - n0 < 10) begin
            miscompares++;
            $display("FAIL random_progress: got %0d pops want >=10", n_pops - n0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        rst = 1'b1; pc_src = 1'b0; branch_addr = 8'h00; id_stall = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
        @(negedge clk);
        test_reset();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_rvalid_pop();
        test_wraparound();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage that supplies the IF/ID pipeline register. It maintains an 8-bit word-addressed PC and issues single-outstanding requests to instruction memory. Returned 16-bit instructions are buffered with their fetch address in a small FIFO and presented to decode under a valid/stall handshake. Branch/jump redirects from later stages flush the buffer and discard any in-flight response.

## Interface

- DEPTH, 2: prefetch FIFO entries; power of 2, minimum 2.
- RESET_PC, 8'h00: PC value loaded on reset.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req  out  1  fetch request.
- imem_addr  out  8  fetch address; equals PC while imem_req=1.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  response data valid; in order; at least 1 cycle after grant.
- imem_rdata  in  16  instruction word.
- pc_src  in  1  redirect strobe from branch resolution.
- branch_addr  in  8  redirect target; sampled when pc_src=1.
- id_stall  in  1  decode not accepting this cycle.
- if_valid  out  1  instruc_out/addr_out hold a valid entry (FIFO head).
- instruc_out  out  16  instruction word at FIFO head.
- addr_out  out  8  fetch address of the instruction at FIFO head.

## Operation

- State: pc[7:0], outstanding (1 bit), req_addr[7:0] (address of the granted request), drop (1 bit), FIFO of DEPTH entries {addr[7:0], instr[15:0]}, count 0..DEPTH.
- Request rule: imem_req = !outstanding && count < DEPTH && !pc_src && !rst. imem_addr = pc.
- Grant (imem_req && imem_gnt): outstanding<=1, req_addr<=pc, pc<=pc+1 modulo 256 (8'hFF wraps to 8'h00).
- Response (imem_rvalid && outstanding): outstanding<=0; if drop=0 and pc_src=0, push {req_addr, imem_rdata}; otherwise discard and clear drop.
- imem_rvalid while outstanding=0 is ignored.
- Pop: if_valid && !id_stall advances the head.
- Push and pop in the same cycle: count unchanged. Overflow cannot occur because a request issues only when a slot is free and at most one request is outstanding.
- Redirect (pc_src=1), with priority over everything except rst:
  - FIFO cleared (count<=0) and pc<=branch_addr.
  - No push or grant that cycle.
  - If a request is outstanding and its response does not arrive this cycle, drop<=1.
  - A pending ungranted request is withdrawn.
- Outputs: if_valid = (count != 0). instruc_out and addr_out are driven from the head entry; they are 16'h0000 and 8'h00 when empty.
- Reset: pc=RESET_PC, outstanding=0, drop=0, count=0, head/tail pointers 0. All outputs are 0, including imem_addr.
- Reset during an outstanding request: that request's later response is ignored because outstanding=0.

## Timing

- Cycle 0 after rst falls: imem_req=1, imem_addr=RESET_PC.
- Grant at cycle N and rvalid at cycle N+L (L≥1): the entry is written at the end of cycle N+L, and if_valid=1 in cycle N+L+1. Minimum IF latency from request to if_valid is 2 cycles.
- Next request is issued earliest in the cycle after the response (N+L+1). Peak throughput is 1 instruction per L+1 cycles.
- Redirect at cycle R: if_valid=0 in cycle R+1. imem_req=1 with imem_addr=branch_addr in cycle R+1 if no request remains outstanding; otherwise it issues after the dropped response returns.
- id_stall has no effect on imem_req except through count reaching DEPTH.

## Test plan

- Reset/startup: RESET_PC=8'h10, memory grants immediately, L=1, id_stall=0 -> requests to 10,11,12…; decode receives (10,mem[10]),(11,mem[11]) in order with no gaps beyond one cycle.
- Backpressure: hold id_stall=1 for 10 cycles -> count reaches 2, imem_req stays 0, instruc_out constant. Release -> entries pop in order and fetch resumes at the next PC.
- Redirect with response in flight: grant at 8'h05, pc_src=1 with branch_addr=8'h40 before rvalid -> mem[05] is never presented; first if_valid shows addr_out=8'h40.
- Redirect coinciding with rvalid and with a pop in the same cycle -> FIFO is empty the next cycle, the word is dropped, drop stays 0, and the fetch at 8'h40 issues next cycle.
- Wrap-around: pc starts at 8'hFE -> addr_out sequence FE, FF, 00, 01.
- Reset mid-operation: assert rst with FIFO full and a request outstanding; late rvalid arrives after rst falls -> the response is ignored, first output is (RESET_PC, mem[RESET_PC]), and all outputs are 0 during rst.
